// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and flag bundle shared by the ALU files
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_INC  = 4'd13,
    OP_DEC  = 4'd14,
    OP_SLTU = 4'd15
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode request and registered result bundle
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       SEL;
  logic [WIDTH-1:0] OUT;
  logic             out_valid;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, A, B, SEL,
    input  OUT, out_valid, carry, zero, negative, overflow
  );

  modport slave (
    input  in_valid, A, B, SEL,
    output OUT, out_valid, carry, zero, negative, overflow
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational result and flag computation for every opcode
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  // INC/DEC reuse the adder/subtractor with a constant second operand
  assign opb  = (sel_i == OP_INC || sel_i == OP_DEC) ? ONE : b_i;
  assign sum  = {1'b0, a_i} + {1'b0, opb};
  assign diff = {1'b0, a_i} - {1'b0, opb};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (sel_i)
      OP_ADD, OP_INC: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a_i[MSB] == opb[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB, OP_DEC: begin
        res = diff[MSB:0];
        c   = diff[WIDTH];
        v   = (a_i[MSB] != opb[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NAND: res = ~(a_i & b_i);
      OP_NOR:  res = ~(a_i | b_i);
      OP_XNOR: res = ~(a_i ^ b_i);
      OP_NOT:  res = ~a_i;
      OP_SHL: begin
        res = {a_i[MSB-1:0], 1'b0};
        c   = a_i[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a_i[MSB:1]};
        c   = a_i[0];
      end
      OP_ROL: begin
        res = {a_i[MSB-1:0], a_i[MSB]};
        c   = a_i[MSB];
      end
      OP_ROR: begin
        res = {a_i[0], a_i[MSB:1]};
        c   = a_i[0];
      end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: res = '0;
    endcase
  end

  assign result_o          = res;
  assign flags_o.carry     = c;
  assign flags_o.zero      = (res == '0);
  assign flags_o.negative  = res[MSB];
  assign flags_o.overflow  = v;
endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered ALU stage with valid qualifier and async reset
module alu_unit import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (bus.A),
    .b_i      (bus.B),
    .sel_i    (bus.SEL),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // Result and flags hold across idle cycles; only the qualifier drops
  always_comb begin
    out_d   = bus.in_valid ? core_res   : out_q;
    flags_d = bus.in_valid ? core_flags : flags_q;
    valid_d = bus.in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.carry     = flags_q.carry;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.overflow  = flags_q.overflow;
endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed and randomized checks of alu_unit against an arithmetic model
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_out;
  logic       exp_valid, exp_c, exp_z, exp_n, exp_v;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } res_t;

  alu_if #(.WIDTH(8)) bus ();
  alu_unit #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic res_t model(input int a, input int b, input int sel);
    res_t r;
    int   x;
    int   sa;
    int   sb;
    bit   c;
    bit   v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c  = 0;
    v  = 0;
    x  = 0;
    case (sel)
      0:  begin x = a + b; c = (x > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1:  begin x = a - b; c = (a < b);   v = (sa - sb > 127) || (sa - sb < -128); end
      2:  x = a & b;
      3:  x = a | b;
      4:  x = a ^ b;
      5:  x = ~(a & b);
      6:  x = ~(a | b);
      7:  x = ~(a ^ b);
      8:  x = ~a;
      9:  begin x = a * 2;                   c = (a >= 128); end
      10: begin x = a / 2;                   c = (a % 2 == 1); end
      11: begin x = a * 2 + a / 128;         c = (a >= 128); end
      12: begin x = a / 2 + (a % 2) * 128;   c = (a % 2 == 1); end
      13: begin x = a + 1; c = (x > 255); v = (sa + 1 > 127); end
      14: begin x = a - 1; c = (a < 1);   v = (sa - 1 < -128); end
      default: x = (a < b) ? 1 : 0;
    endcase
    x     = x & 255;
    r.out = x[7:0];
    r.c   = c;
    r.z   = (x == 0);
    r.n   = (x >= 128);
    r.v   = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/out"},   32'(bus.OUT),       32'(exp_out));
    check({tag, "/valid"}, 32'(bus.out_valid), 32'(exp_valid));
    check({tag, "/carry"}, 32'(bus.carry),     32'(exp_c));
    check({tag, "/zero"},  32'(bus.zero),      32'(exp_z));
    check({tag, "/neg"},   32'(bus.negative),  32'(exp_n));
    check({tag, "/ovf"},   32'(bus.overflow),  32'(exp_v));
  endtask

  task automatic clear_exp();
    exp_out = 8'h00; exp_valid = 0; exp_c = 0; exp_z = 0; exp_n = 0; exp_v = 0;
  endtask

  // Drive one cycle of input, then check the registered outputs just after the capturing edge
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] s, input string tag);
    res_t r;
    @(negedge clk);
    bus.in_valid = v; bus.A = a; bus.B = b; bus.SEL = s;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      clear_exp();
    end else if (v) begin
      r = model(int'(a), int'(b), int'(s));
      exp_out = r.out; exp_c = r.c; exp_z = r.z; exp_n = r.n; exp_v = r.v;
      exp_valid = 1;
    end else begin
      exp_valid = 0;
    end
    check_all(tag);
  endtask

  initial begin
    logic [7:0] sweep_tbl [16];
    logic [7:0] held;
    sweep_tbl = '{8'h08, 8'hFE, 8'h01, 8'h07, 8'h06, 8'hFE, 8'hF8, 8'hF9,
                  8'hFC, 8'h06, 8'h01, 8'h06, 8'h81, 8'h04, 8'h02, 8'h01};
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.SEL = '0;
    clear_exp();

    for (int i = 0; i < 4; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), "reset_hold");

    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    for (int s = 0; s < 16; s++) begin
      step(1'b1, 8'h03, 8'h05, 4'(s), "sweep");
      check("sweep_tbl", 32'(bus.OUT), 32'(sweep_tbl[s]));
      if (s == 1) begin
        check("sub_carry", 32'(bus.carry), 32'd1);
        check("sub_neg",   32'(bus.negative), 32'd1);
      end
    end

    step(1'b1, 8'hFF, 8'h01, 4'd0, "add_ff_01");
    check("add_ff_01_c", {bus.OUT, bus.carry, bus.zero}, {8'h00, 1'b1, 1'b1});
    step(1'b1, 8'h7F, 8'h01, 4'd0, "add_7f_01");
    check("add_7f_01_v", {bus.OUT, bus.overflow, bus.negative}, {8'h80, 1'b1, 1'b1});
    step(1'b1, 8'h80, 8'h01, 4'd1, "sub_80_01");
    check("sub_80_01_v", {bus.OUT, bus.overflow}, {8'h7F, 1'b1});
    step(1'b1, 8'hFF, 8'h00, 4'd13, "inc_ff");
    check("inc_ff_wrap", 32'(bus.OUT), 32'h00);
    step(1'b1, 8'h00, 8'h00, 4'd14, "dec_00");
    check("dec_00_wrap", {bus.OUT, bus.carry}, {8'hFF, 1'b1});

    step(1'b1, 8'h81, 8'h00, 4'd9,  "shl_81");
    check("shl_81_k", {bus.OUT, bus.carry}, {8'h02, 1'b1});
    step(1'b1, 8'h81, 8'h00, 4'd10, "shr_81");
    check("shr_81_k", {bus.OUT, bus.carry}, {8'h40, 1'b1});
    step(1'b1, 8'h81, 8'h00, 4'd11, "rol_81");
    check("rol_81_k", 32'(bus.OUT), 32'h03);
    step(1'b1, 8'h81, 8'h00, 4'd12, "ror_81");
    check("ror_81_k", 32'(bus.OUT), 32'hC0);

    step(1'b1, 8'h10, 8'h22, 4'd0, "vpat1");
    held = 8'h32;
    step(1'b0, 8'hAA, 8'h55, 4'd3, "vpat0");
    check("vpat_hold", 32'(bus.OUT), 32'(held));
    step(1'b1, 8'h09, 8'h04, 4'd1, "vpat1b");
    step(1'b1, 8'h0F, 8'hF0, 4'd4, "vpat1c");

    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 4'($urandom), "rand");

    step(1'b1, 8'h7F, 8'h7F, 4'd0, "pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check_all("async_reset");
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h12, 8'h34, 4'd0, "post_reset_idle");
    step(1'b1, 8'h12, 8'h34, 4'd0, "post_reset_add");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
